ycbcr2rgb: RTL and testbench

//  Inverse of the rgb2ycbcr stage: converts a full-range BT.601 (JFIF) 8-bit YCbCr

---
 rtl/ycbcr2rgb_if.sv | 29 ++
 rtl/ycbcr2rgb.sv | 123 ++++++++++++
 tb/tb_ycbcr2rgb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ycbcr2rgb_if.sv
// ycbcr2rgb_if: pixel stream bundle for the YCbCr -> RGB converter.
//   Y/Cb/Cr, in_hsync/in_vsync/in_de : YCbCr pixel and timing into the converter
//   R/G/B, out_hsync/out_vsync/out_de: RGB pixel and delayed timing out of it
//   master : the side that sources YCbCr and sinks RGB (upstream chain / bench)
//   slave  : the converter itself
interface ycbcr2rgb_if;
    logic [7:0] Y;
    logic [7:0] Cb;
    logic [7:0] Cr;
    logic       in_hsync;
    logic       in_vsync;
    logic       in_de;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic       out_hsync;
    logic       out_vsync;
    logic       out_de;

    modport master (
        output Y, Cb, Cr, in_hsync, in_vsync, in_de,
        input  R, G, B, out_hsync, out_vsync, out_de
    );

    modport slave (
        input  Y, Cb, Cr, in_hsync, in_vsync, in_de,
        output R, G, B, out_hsync, out_vsync, out_de
    );
endinterface

// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: full-range BT.601 (JFIF) YCbCr -> RGB, 4-stage pipeline.
//   clk   : pixel clock
//   rst_n : synchronous active-low reset, clears every pipeline register
//   ce    : clock enable, 0 freezes all stages including the sync delay line
//   vid   : slave side of ycbcr2rgb_if (YCbCr + syncs in, RGB + syncs out)
// Data and syncs share a 4 ce-cycle latency; blanking pixels are converted too.
module ycbcr2rgb #(
    parameter int FRAC  = 14,
    parameter int K_RCR = 22970,
    parameter int K_GCB = 5638,
    parameter int K_GCR = 11700,
    parameter int K_BCB = 29032
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    ycbcr2rgb_if.slave  vid
);
    // 26-bit signed holds Y<<14 plus any product sum without overflow.
    localparam int W = 26;
    localparam logic signed [W-1:0] KRCR = W'(K_RCR);
    localparam logic signed [W-1:0] KGCB = W'(K_GCB);
    localparam logic signed [W-1:0] KGCR = W'(K_GCR);
    localparam logic signed [W-1:0] KBCB = W'(K_BCB);
    localparam logic signed [W-1:0] RND  = W'(2 ** (FRAC - 1));

    // S1: offset-removed operands
    logic signed [8:0]   y1_q,  y1_d;
    logic signed [8:0]   cb1_q, cb1_d;
    logic signed [8:0]   cr1_q, cr1_d;
    // S2: products and scaled luma
    logic signed [W-1:0] y2_q,   y2_d;
    logic signed [W-1:0] pr2_q,  pr2_d;
    logic signed [W-1:0] pgb2_q, pgb2_d;
    logic signed [W-1:0] pgr2_q, pgr2_d;
    logic signed [W-1:0] pb2_q,  pb2_d;
    // S3: rounded sums
    logic signed [W-1:0] sr3_q, sr3_d;
    logic signed [W-1:0] sg3_q, sg3_d;
    logic signed [W-1:0] sb3_q, sb3_d;
    // S4: saturated outputs
    logic [7:0]          r_q, r_d;
    logic [7:0]          g_q, g_d;
    logic [7:0]          b_q, b_d;
    // sync delay line, {hsync, vsync, de} per stage
    logic [3:0][2:0]     sync_q, sync_d;

    function automatic logic [7:0] sat8(input logic signed [W-1:0] s);
        logic signed [W-1:0] t;
        t = s >>> FRAC;
        if (t < 0)
            return '0;
        else if (t > 255)
            return '1;
        else
            return t[7:0];
    endfunction

    always_comb begin
        y1_d   = $signed({1'b0, vid.Y});
        cb1_d  = $signed({1'b0, vid.Cb}) - 9'sd128;
        cr1_d  = $signed({1'b0, vid.Cr}) - 9'sd128;

        y2_d   = W'(y1_q) <<< FRAC;
        pr2_d  = KRCR * W'(cr1_q);
        pgb2_d = KGCB * W'(cb1_q);
        pgr2_d = KGCR * W'(cr1_q);
        pb2_d  = KBCB * W'(cb1_q);

        sr3_d  = y2_q + pr2_q + RND;
        sg3_d  = y2_q - pgb2_q - pgr2_q + RND;
        sb3_d  = y2_q + pb2_q + RND;

        r_d    = sat8(sr3_q);
        g_d    = sat8(sg3_q);
        b_d    = sat8(sb3_q);

        sync_d = {sync_q[2:0], {vid.in_hsync, vid.in_vsync, vid.in_de}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y1_q   <= '0;
            cb1_q  <= '0;
            cr1_q  <= '0;
            y2_q   <= '0;
            pr2_q  <= '0;
            pgb2_q <= '0;
            pgr2_q <= '0;
            pb2_q  <= '0;
            sr3_q  <= '0;
            sg3_q  <= '0;
            sb3_q  <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            sync_q <= '0;
        end else if (ce) begin
            y1_q   <= y1_d;
            cb1_q  <= cb1_d;
            cr1_q  <= cr1_d;
            y2_q   <= y2_d;
            pr2_q  <= pr2_d;
            pgb2_q <= pgb2_d;
            pgr2_q <= pgr2_d;
            pb2_q  <= pb2_d;
            sr3_q  <= sr3_d;
            sg3_q  <= sg3_d;
            sb3_q  <= sb3_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            sync_q <= sync_d;
        end
    end

    assign vid.R         = r_q;
    assign vid.G         = g_q;
    assign vid.B         = b_q;
    assign vid.out_hsync = sync_q[3][2];
    assign vid.out_vsync = sync_q[3][1];
    assign vid.out_de    = sync_q[3][0];
endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb_ycbcr2rgb: randomized self-checking bench for ycbcr2rgb.
// Reference: BT.601 integer arithmetic per pixel, plus a 4-deep ce-qualified
// delay of expected pixels; round-trip phase uses an rgb2ycbcr forward model.
module tb_ycbcr2rgb;
    logic clk = 1'b0;
    logic rst_n;
    logic ce;
    ycbcr2rgb_if vid ();

    ycbcr2rgb #(
        .FRAC  (14),
        .K_RCR (22970),
        .K_GCB (5638),
        .K_GCR (11700),
        .K_BCB (29032)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .vid   (vid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int r, g, b;
        int sync;
        bit rt;
        int or_, og, ob;
    } px_t;

    px_t st [4];

    // round-trip bookkeeping for the pixel currently being driven
    bit rt_cur = 1'b0;
    int orr = 0, ogg = 0, obb = 0;

    function automatic int clamp8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic px_t convert(input int y, input int cb, input int cr);
        px_t p;
        int  c_b, c_r;
        c_b = cb - 128;
        c_r = cr - 128;
        p = '{default: 0};
        p.r = clamp8((y * 16384 + 22970 * c_r + 8192) >>> 14);
        p.g = clamp8((y * 16384 - 5638 * c_b - 11700 * c_r + 8192) >>> 14);
        p.b = clamp8((y * 16384 + 29032 * c_b + 8192) >>> 14);
        return p;
    endfunction

    // JFIF forward transform, rounded to nearest
    task automatic rgb2ycc(input int r, input int g, input int b,
                           output int y, output int cb, output int cr);
        y  = clamp8((19595 * r + 38470 * g + 7471 * b + 32768) >>> 16);
        cb = clamp8((-11059 * r - 21709 * g + 32768 * b + 8421376) >>> 16);
        cr = clamp8((32768 * r - 27439 * g - 5329 * b + 8421376) >>> 16);
    endtask

    always @(posedge clk) begin
        px_t nx;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) st[i] = '{default: 0};
        end else if (ce) begin
            nx      = convert(int'(vid.Y), int'(vid.Cb), int'(vid.Cr));
            nx.sync = int'({vid.in_hsync, vid.in_vsync, vid.in_de});
            nx.rt   = rt_cur;
            nx.or_  = orr;
            nx.og   = ogg;
            nx.ob   = obb;
            st[3] = st[2];
            st[2] = st[1];
            st[1] = st[0];
            st[0] = nx;
        end
    end

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic step();
        @(negedge clk);
        check_val("R",    int'(vid.R), st[3].r);
        check_val("G",    int'(vid.G), st[3].g);
        check_val("B",    int'(vid.B), st[3].b);
        check_val("sync", int'({vid.out_hsync, vid.out_vsync, vid.out_de}), st[3].sync);
        if (st[3].rt) begin
            check_val("rt_R", int'(absd(int'(vid.R), st[3].or_) <= 2), 1);
            check_val("rt_G", int'(absd(int'(vid.G), st[3].og) <= 2), 1);
            check_val("rt_B", int'(absd(int'(vid.B), st[3].ob) <= 2), 1);
        end
    endtask

    task automatic drive(input int y, input int cb, input int cr, input logic [2:0] s);
        vid.Y        = 8'(y);
        vid.Cb       = 8'(cb);
        vid.Cr       = 8'(cr);
        vid.in_hsync = s[2];
        vid.in_vsync = s[1];
        vid.in_de    = s[0];
    endtask

    task automatic directed(input string tag, input int y, input int cb, input int cr,
                            input int er, input int eg, input int eb);
        drive(y, cb, cr, 3'b001);
        ce = 1'b1;
        repeat (4) step();
        check_val({tag, "_R"}, int'(vid.R), er);
        check_val({tag, "_G"}, int'(vid.G), eg);
        check_val({tag, "_B"}, int'(vid.B), eb);
        check_val({tag, "_de"}, int'(vid.out_de), 1);
    endtask

    initial begin
        int ry, rcb, rcr;
        rst_n = 1'b0;
        ce    = 1'b0;
        drive(0, 0, 0, 3'b000);
        repeat (3) step();
        check_val("rst_RGB",  int'({vid.R, vid.G, vid.B}), 0);
        check_val("rst_sync", int'({vid.out_hsync, vid.out_vsync, vid.out_de}), 0);

        rst_n = 1'b1;
        directed("gray", 128, 128, 128, 128, 128, 128);
        directed("mid",  200, 100, 150, 231, 194, 150);
        directed("hi",   255, 128, 255, 255, 164, 255);
        directed("lo",   0,   0,   0,   0,   135, 0);

        // random pixels, random ce gaps, sparse sync pulses
        for (int i = 0; i < 600; i++) begin
            logic [2:0] s;
            s[2] = ($urandom_range(0, 9) == 0);
            s[1] = ($urandom_range(0, 19) == 0);
            s[0] = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), s);
            ce = ($urandom_range(0, 9) < 7);
            step();
        end

        // random ce with mid-line resets
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  3'($urandom_range(0, 7)));
            ce    = ($urandom_range(0, 9) < 6);
            rst_n = ($urandom_range(0, 29) != 0);
            step();
            if (!rst_n) begin
                check_val("midrst_RGB",  int'({vid.R, vid.G, vid.B}), 0);
                check_val("midrst_sync", int'({vid.out_hsync, vid.out_vsync, vid.out_de}), 0);
            end
        end
        rst_n = 1'b1;

        // round trip: RGB -> YCbCr in the bench, back through the DUT
        for (int i = 0; i < 600; i++) begin
            orr = $urandom_range(0, 255);
            ogg = $urandom_range(0, 255);
            obb = $urandom_range(0, 255);
            rgb2ycc(orr, ogg, obb, ry, rcb, rcr);
            rt_cur = 1'b1;
            drive(ry, rcb, rcr, 3'b001);
            ce = ($urandom_range(0, 9) < 7);
            if (i == 300) rst_n = 1'b0;
            else          rst_n = 1'b1;
            step();
        end
        rt_cur = 1'b0;
        ce     = 1'b1;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
